// File: rtl/fft_uart_frame_tx_if.sv
// FIFO read port between the frame transmitter and the result FIFO.
// The transmitter is the master; it issues read strobes.
interface fft_uart_frame_tx_if;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [13:0] fifo_dout;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fft_uart_frame_tx.sv
// Drains one frame of 14-bit FFT samples from the result FIFO and sends
// it over UART 8N1 as a two-byte header plus two bytes per sample.
module fft_uart_frame_tx #(
  parameter int         BAUD_DIV  = 434,
  parameter int         FRAME_LEN = 1024,
  parameter logic [7:0] HDR0      = 8'hAA,
  parameter logic [7:0] HDR1      = 8'h55
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_ready,
  fft_uart_frame_tx_if.master fifo,
  output logic                uart_txd,
  output logic                tx_busy,
  output logic                tx_dong_sig
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] F_LEN  = CW'(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE,
    HDR_A,
    HDR_B,
    S_HI,
    S_LO,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          active;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic [CW-1:0] smp_cnt;
  logic          armed;
  logic          need_fetch;
  logic          rd_pend;
  logic          nxt_valid;
  logic [13:0]   smp_reg;

  logic          byte_end;
  logic          smp_ok;
  logic [13:0]   smp_src;
  logic          rd_en;
  logic          load;
  logic [7:0]    load_byte;
  logic          take;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          fetch_set;
  logic          arm_clr;
  logic          arm_set;

  assign byte_end = active && (bit_cnt == 4'd9) &&
                    (baud_cnt == B_LAST);

  // A sample is usable either from the holding register or straight
  // off the FIFO bus in its capture cycle.
  assign smp_ok  = nxt_valid || rd_pend;
  assign smp_src = nxt_valid ? smp_reg : fifo.fifo_dout;

  assign rd_en = need_fetch && !fifo.fifo_empty && !rst;
  assign fifo.fifo_rd_en = rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_byte = 8'h00;
    take      = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    fetch_set = 1'b0;
    arm_clr   = 1'b0;
    arm_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_ready && armed) begin
          state_nxt = HDR_A;
          load      = 1'b1;
          load_byte = HDR0;
          cnt_clr   = 1'b1;
          arm_clr   = 1'b1;
        end else if (!tx_ready) begin
          arm_set = 1'b1;
        end
      end
      HDR_A: begin
        if (byte_end) begin
          state_nxt = HDR_B;
          load      = 1'b1;
          load_byte = HDR1;
          fetch_set = 1'b1;
        end
      end
      HDR_B: begin
        if (byte_end) begin
          state_nxt = S_HI;
          if (smp_ok) begin
            load      = 1'b1;
            load_byte = {2'b00, smp_src[13:8]};
            take      = 1'b1;
          end
        end
      end
      S_HI: begin
        if (!active) begin
          if (smp_ok) begin
            load      = 1'b1;
            load_byte = {2'b00, smp_src[13:8]};
            take      = 1'b1;
          end
        end else if (byte_end) begin
          state_nxt = S_LO;
          load      = 1'b1;
          load_byte = smp_reg[7:0];
          cnt_inc   = 1'b1;
          fetch_set = (smp_cnt + CW'(1)) < F_LEN;
        end
      end
      S_LO: begin
        if (byte_end) begin
          if (smp_cnt < F_LEN) begin
            state_nxt = S_HI;
            if (smp_ok) begin
              load      = 1'b1;
              load_byte = {2'b00, smp_src[13:8]};
              take      = 1'b1;
            end
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= 1'b0;
      bit_cnt    <= '0;
      baud_cnt   <= '0;
      shreg      <= '0;
      smp_cnt    <= '0;
      armed      <= 1'b1;
      need_fetch <= 1'b0;
      rd_pend    <= 1'b0;
      nxt_valid  <= 1'b0;
      smp_reg    <= '0;
    end else begin
      if (load) begin
        shreg    <= load_byte;
        bit_cnt  <= '0;
        baud_cnt <= '0;
        active   <= 1'b1;
      end else if (active) begin
        if (baud_cnt == B_LAST) begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (bit_cnt != 4'd0) begin
            shreg <= {1'b1, shreg[7:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + BW'(1);
        end
      end

      if (cnt_clr) begin
        smp_cnt <= '0;
      end else if (cnt_inc) begin
        smp_cnt <= smp_cnt + CW'(1);
      end

      if (arm_clr) begin
        armed <= 1'b0;
      end else if (arm_set) begin
        armed <= 1'b1;
      end

      if (fetch_set) begin
        need_fetch <= 1'b1;
      end else if (rd_en) begin
        need_fetch <= 1'b0;
      end

      rd_pend <= rd_en;

      if (rd_pend) begin
        smp_reg <= fifo.fifo_dout;
      end

      if (take) begin
        nxt_valid <= 1'b0;
      end else if (rd_pend) begin
        nxt_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    if (!active) begin
      uart_txd = 1'b1;
    end else if (bit_cnt == 4'd0) begin
      uart_txd = 1'b0;
    end else if (bit_cnt == 4'd9) begin
      uart_txd = 1'b1;
    end else begin
      uart_txd = shreg[0];
    end
  end

  assign tx_busy = (state == HDR_A) || (state == HDR_B) ||
                   (state == S_HI)  || (state == S_LO);
  assign tx_dong_sig = (state == DONE);

endmodule

// File: tb/tb_fft_uart_frame_tx.sv
// Bench for fft_uart_frame_tx: a short fast-baud instance for frame
// behaviour and a full-rate single-sample instance for bit timing.
module tb_fft_uart_frame_tx;
  localparam int BA = 8;
  localparam int FA = 4;
  localparam int BB = 434;
  localparam int FB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rdy_a, rdy_b;
  logic txd_a, busy_a, dong_a;
  logic txd_b, busy_b, dong_b;

  fft_uart_frame_tx_if f_a ();
  fft_uart_frame_tx_if f_b ();

  fft_uart_frame_tx #(.BAUD_DIV(BA), .FRAME_LEN(FA)) dut_a (
    .clk(clk), .rst(rst_a), .tx_ready(rdy_a), .fifo(f_a.master),
    .uart_txd(txd_a), .tx_busy(busy_a), .tx_dong_sig(dong_a)
  );

  fft_uart_frame_tx #(.BAUD_DIV(BB), .FRAME_LEN(FB)) dut_b (
    .clk(clk), .rst(rst_b), .tx_ready(rdy_b), .fifo(f_b.master),
    .uart_txd(txd_b), .tx_busy(busy_b), .tx_dong_sig(dong_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] mem_a [0:63];
  logic [13:0] mem_b [0:63];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  assign f_a.fifo_empty = (wp_a == rp_a);
  assign f_b.fifo_empty = (wp_b == rp_b);

  int rd_cnt_a = 0, rd_cnt_b = 0, dong_cnt_a = 0, dong_cnt_b = 0;
  int bad_rd = 0;
  int rdc_a[$];

  always @(posedge clk) begin
    if (f_a.fifo_rd_en) begin
      f_a.fifo_dout <= mem_a[rp_a[5:0]];
      rp_a <= rp_a + 1;
      rd_cnt_a <= rd_cnt_a + 1;
      rdc_a.push_back(cyc);
      if (f_a.fifo_empty) bad_rd <= bad_rd + 1;
    end
    if (f_b.fifo_rd_en) begin
      f_b.fifo_dout <= mem_b[rp_b[5:0]];
      rp_b <= rp_b + 1;
      rd_cnt_b <= rd_cnt_b + 1;
      if (f_b.fifo_empty) bad_rd <= bad_rd + 1;
    end
    if (dong_a) dong_cnt_a <= dong_cnt_a + 1;
    if (dong_b) dong_cnt_b <= dong_cnt_b + 1;
  end

  logic [7:0] rxq_a[$];
  logic [7:0] rxq_b[$];
  int viol_b = 0;

  // Strict receiver: every cycle of each bit must hold the bit's level.
  task automatic rx_byte(input bit which, input int baud,
                         output logic [7:0] b, output int bad);
    logic l, first;
    b = '0;
    bad = 0;
    first = 1'b0;
    for (int k = 0; k < 10 * baud; k++) begin
      if (k > 0) @(negedge clk);
      l = which ? txd_b : txd_a;
      if (k % baud == 0) begin
        first = l;
        if (k == 0 && l !== 1'b0) bad++;
        if (k == 9 * baud && l !== 1'b1) bad++;
      end else if (l !== first) begin
        bad++;
      end
      if (k % baud == baud / 2 && k / baud >= 1 && k / baud <= 8)
        b[k / baud - 1] = l;
    end
  endtask

  initial begin : rx_a
    logic [7:0] b;
    int bad;
    forever begin
      @(negedge clk);
      if (txd_a === 1'b0) begin
        rx_byte(1'b0, BA, b, bad);
        rxq_a.push_back(b);
      end
    end
  end

  initial begin : rx_b
    logic [7:0] b;
    int bad;
    forever begin
      @(negedge clk);
      if (txd_b === 1'b0) begin
        rx_byte(1'b1, BB, b, bad);
        rxq_b.push_back(b);
        viol_b = viol_b + bad;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_a[$];
  logic [13:0] exp_b[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit which, input logic [13:0] s);
    if (which) begin
      mem_b[wp_b[5:0]] = s;
      wp_b++;
      exp_b.push_back(s);
    end else begin
      mem_a[wp_a[5:0]] = s;
      wp_a++;
      exp_a.push_back(s);
    end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 14'($urandom_range(0, 16383)));
  endtask

  task automatic start(input bit which, input bit hold,
                       input string tag, output int c0);
    if (which) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    if (!hold) begin
      if (which) rdy_b = 1'b0; else rdy_a = 1'b0;
    end
    c0 = cyc;
    chk({tag, "_start_txd"}, which ? txd_b : txd_a, 0);
    chk({tag, "_start_busy"}, which ? busy_b : busy_a, 1);
  endtask

  task automatic wait_dong(input bit which, input int bound,
                           input string tag, output int c1);
    bit found;
    found = 1'b0;
    c1 = -1;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (which ? dong_b : dong_a) begin
        found = 1'b1;
        c1 = cyc;
      end
    end
    chk({tag, "_dong_seen"}, found, 1);
    if (found) chk({tag, "_dong_busy"}, which ? busy_b : busy_a, 0);
  endtask

  task automatic check_frame(input bit which, input int rx0,
                             input int n, input string tag);
    logic [7:0] e[$];
    logic [13:0] s;
    int got;
    logic [31:0] v;
    e.push_back(8'hAA);
    e.push_back(8'h55);
    for (int i = 0; i < n; i++) begin
      s = which ? exp_b.pop_front() : exp_a.pop_front();
      e.push_back(8'(s / 256));
      e.push_back(8'(s % 256));
    end
    got = (which ? rxq_b.size() : rxq_a.size()) - rx0;
    chk({tag, "_nbytes"}, got, e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < got) v = {24'h0, which ? rxq_b[rx0 + i] : rxq_a[rx0 + i]};
      else v = 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), v, {24'h0, e[i]});
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, c1, rx0, rd0, dn0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    step(3);
    chk("rst_txd", txd_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_dong", dong_a, 0);
    chk("rst_rd", f_a.fifo_rd_en, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(2);
    chk("idle_txd", txd_a, 1);

    // Basic frame
    push(1'b0, 14'h3FFF);
    push(1'b0, 14'h0123);
    push(1'b0, 14'h2A5C);
    push(1'b0, 14'h0000);
    rx0 = rxq_a.size();
    rd0 = rd_cnt_a;
    dn0 = dong_cnt_a;
    start(1'b0, 1'b0, "basic", c0);
    wait_dong(1'b0, 2000, "basic", c1);
    chk("basic_len", c1 - c0, 800);
    step(2);
    check_frame(1'b0, rx0, 4, "basic");
    chk("basic_reads", rd_cnt_a - rd0, 4);
    chk("basic_dongs", dong_cnt_a - dn0, 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("basic_rdcyc%0d", k),
          (rdc_a.size() > rd0 + k) ? rdc_a[rd0 + k] - c0 : -1,
          80 + 160 * k);

    // Underflow stall
    push_rand(2);
    rx0 = rxq_a.size();
    rd0 = rd_cnt_a;
    start(1'b0, 1'b0, "stall", c0);
    step(500);
    chk("stall_idle_txd", txd_a, 1);
    chk("stall_busy", busy_a, 1);
    step(100);
    push_rand(2);
    wait_dong(1'b0, 2000, "stall", c1);
    chk("stall_len", c1 - c0, 922);
    step(2);
    check_frame(1'b0, rx0, 4, "stall");
    chk("stall_reads", rd_cnt_a - rd0, 4);
    chk("stall_bad_rd", bad_rd, 0);

    // Held request: one frame only, then re-arm
    push_rand(8);
    rx0 = rxq_a.size();
    rd0 = rd_cnt_a;
    dn0 = dong_cnt_a;
    start(1'b0, 1'b1, "held", c0);
    step(2400);
    chk("held_dongs", dong_cnt_a - dn0, 1);
    chk("held_reads", rd_cnt_a - rd0, 4);
    chk("held_busy", busy_a, 0);
    check_frame(1'b0, rx0, 4, "held");
    rdy_a = 1'b0;
    step(1);
    rx0 = rxq_a.size();
    start(1'b0, 1'b0, "rearm", c0);
    wait_dong(1'b0, 2000, "rearm", c1);
    chk("rearm_len", c1 - c0, 800);
    step(2);
    check_frame(1'b0, rx0, 4, "rearm");

    // Reset during bit 3 of the fifth byte
    push_rand(4);
    rd0 = rd_cnt_a;
    dn0 = dong_cnt_a;
    start(1'b0, 1'b0, "mrst", c0);
    step(347);
    chk("mrst_reads_before", rd_cnt_a - rd0, 2);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    chk("mrst_txd", txd_a, 1);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_dong", dong_a, 0);
    step(200);
    chk("mrst_no_reads", rd_cnt_a - rd0, 2);
    chk("mrst_no_dong", dong_cnt_a - dn0, 0);
    void'(exp_a.pop_front());
    void'(exp_a.pop_front());
    push_rand(2);
    rx0 = rxq_a.size();
    start(1'b0, 1'b0, "fresh", c0);
    wait_dong(1'b0, 2000, "fresh", c1);
    chk("fresh_len", c1 - c0, 800);
    step(2);
    check_frame(1'b0, rx0, 4, "fresh");

    // Full-rate bit timing, single-sample frame
    push(1'b1, 14'h1ABC);
    rx0 = rxq_b.size();
    start(1'b1, 1'b0, "minb", c0);
    wait_dong(1'b1, 20000, "minb", c1);
    chk("minb_len", c1 - c0, 4 * 10 * BB);
    step(2);
    check_frame(1'b1, rx0, 1, "minb");
    chk("minb_bit_viol", viol_b, 0);
    chk("minb_reads", rd_cnt_b, 1);
    chk("minb_dongs", dong_cnt_b, 1);
    chk("minb_idle_txd", txd_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
